// File: rtl/mux_arbiter_pkg.sv
// Shared constants, output-register state encoding and helpers for mux_arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rr_pick: combinational 4-way round-robin priority picker.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is used.
// Ports:
//   req_eff  in  4  eligible requests
//   ptr      in  2  highest-priority index for this pick
//   win_oh   out 4  one-hot winner (0 when nothing requests)
//   win_idx  out 2  winner index (0 when nothing requests)
//   any      out 1  at least one eligible request
module rr_pick
  import mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_eff,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [SEL_W-1:0]   win_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_shift;
  logic [NUM_REQ-1:0]   req_rot;
  logic [SEL_W-1:0]     offset;

  // Rotate so that bit 0 of req_rot is the requester at ptr; the lowest set
  // bit of the rotated vector is then the round-robin winner.
  assign req_dbl   = {req_eff, req_eff};
  assign req_shift = req_dbl >> ptr;
  assign req_rot   = req_shift[NUM_REQ-1:0];

  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = SEL_W'(k);
    end
  end

  assign any     = |req_eff;
  assign win_idx = any ? (ptr + offset) : '0;
  assign win_oh  = any ? onehot(ptr + offset) : '0;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin share of a 4:1 word mux feeding one registered output stream.
// Latency: 1 cycle from granted request to out_valid/out_data/sel.
// Backpressure: out_ready low while full holds the output and suppresses all grants.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req[3:0]              per-requester word valid
//   data_in[4*WIDTH-1:0]  requester words, word i at [i*WIDTH +: WIDTH]
//   last[3:0]             end-of-burst markers (only used with MUX_ARB_LOCK_EN)
//   gnt[3:0]              one-hot capture acknowledge (combinational)
//   sel[1:0]              index of requester whose word sits in out_data
//   out_valid/out_data    registered output word
//   out_ready             downstream accepts out_data
// Build option MUX_ARB_LOCK_EN: once a requester wins a beat without last,
// it keeps the mux until it delivers a beat with last set.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  input  logic [NUM_REQ-1:0]       last,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready
);

  out_state_e          state_q;
  out_state_e          state_d;
  logic [SEL_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  req_eff;
  logic [NUM_REQ-1:0]  win_oh;
  logic [SEL_W-1:0]    win_idx;
  logic                win_any;
  logic                load;
  logic [WIDTH-1:0]    word_sel;

`ifdef MUX_ARB_LOCK_EN
  logic                lock_vld;
  logic [SEL_W-1:0]    lock_idx;

  // While a burst is open only the lock owner is eligible.
  assign req_eff = lock_vld ? (req & onehot(lock_idx)) : req;
`else
  logic unused_last;
  assign unused_last = ^last;
  assign req_eff     = req;
`endif

  rr_pick u_rr_pick (
    .req_eff (req_eff),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  assign out_valid = (state_q == ST_FULL);

  // Grants are held off during reset so nothing is acknowledged that will
  // not be captured.
  assign load = !rst && win_any && (!out_valid || out_ready);
  assign gnt  = load ? win_oh : '0;

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) word_sel = data_in[i*WIDTH +: WIDTH];
    end
  end

  // Output register occupancy FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !load) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Payload and select only change on a load; a drain leaves them as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      sel      <= '0;
    end else if (load) begin
      out_data <= word_sel;
      sel      <= win_idx;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // The pointer only moves past a requester once its burst is closed, so the
  // next arbitration after a burst starts at the following requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else if (load) begin
      if (last[win_idx]) begin
        ptr      <= win_idx + SEL_W'(1);
        lock_vld <= 1'b0;
      end else begin
        lock_vld <= 1'b1;
        lock_idx <= win_idx;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= '0;
    else if (load) ptr <= win_idx + SEL_W'(1);
  end
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter with a queue-free reference model of the
// round-robin rules checked every negedge, plus literal expectations.
module tb_mux_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] data_in;
  logic [3:0]     last;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;

  int total = 0;
  int bad   = 0;

  mux_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .last      (last),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    data_in[i*W +: W] = v;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset held across at least one falling edge, released after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  bit         m_full;
  logic [W-1:0] m_data;
  int         m_sel;
  int         m_ptr;
  bit         m_lock;
  int         m_lock_idx;

  initial begin : compare
    int w;
    int idx;
    logic [3:0] eff;
    logic [3:0] exp_gnt;
    bit take;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_full = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = 0; m_lock_idx = 0;
        chk("m_rst_valid", out_valid, 0);
        chk("m_rst_data",  out_data, 0);
        chk("m_rst_sel",   sel, 0);
        chk("m_rst_gnt",   gnt, 0);
      end else begin
        chk("m_valid", out_valid, m_full);
        chk("m_data",  out_data, m_data);
        chk("m_sel",   sel, m_sel);
        eff = req;
`ifdef MUX_ARB_LOCK_EN
        if (m_lock) eff = req & (4'b0001 << m_lock_idx);
`endif
        w = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (w < 0 && eff[idx]) w = idx;
        end
        take = (w >= 0) && (!m_full || out_ready);
        exp_gnt = take ? (4'b0001 << w) : 4'b0000;
        chk("m_gnt", gnt, exp_gnt);
        if (take) begin
          m_full = 1;
          m_data = data_in[w*W +: W];
          m_sel  = w;
`ifdef MUX_ARB_LOCK_EN
          if (last[w]) begin
            m_lock = 0;
            m_ptr  = (w + 1) % 4;
          end else begin
            m_lock = 1;
            m_lock_idx = w;
          end
`else
          m_ptr = (w + 1) % 4;
`endif
        end else if (m_full && out_ready) begin
          m_full = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] seq_gnt [5];
  logic [3:0] lock_gnt [4];
  int cnt0;
  int cnt1;

  initial begin : stim
    rst       = 1'b1;
    req       = 4'b1111;
    last      = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_word(i, W'(8'hA0 + i));

    // Reset state with everyone requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_sel",   sel, 0);
    chk("rst_gnt",   gnt, 0);
    rst = 1'b0;
    req = 4'b0000;

    // Single request from requester 2.
    cyc();
    set_word(2, 8'h01);
    req = 4'b0100;
    #1;
    chk("single_gnt", gnt, 4'b0100);
    cyc();
    req = 4'b0000;
    #1;
    chk("single_valid", out_valid, 1);
    chk("single_sel",   sel, 2);
    chk("single_data",  out_data, 8'h01);

    // Full rotation from a fresh pointer.
    do_reset();
    seq_gnt[0] = 4'b0001; seq_gnt[1] = 4'b0010; seq_gnt[2] = 4'b0100;
    seq_gnt[3] = 4'b1000; seq_gnt[4] = 4'b0001;
    for (int i = 0; i < 4; i++) set_word(i, W'(8'hA0 + i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_gnt", gnt, seq_gnt[k]);
      cyc();
      chk("rr_valid", out_valid, 1);
    end
    chk("rr_last_data", out_data, 8'hA0);

    // Stall: nothing granted, output frozen, resume at requester 1.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_gnt", gnt, 0);
      cyc();
      chk("stall_sel",  sel, 0);
      chk("stall_data", out_data, 8'hA0);
    end
    out_ready = 1'b1;
    #1;
    chk("resume_gnt", gnt, 4'b0010);
    cyc();
    chk("resume_sel", sel, 1);

    // Drain with no requests: empties, payload held.
    req = 4'b0000;
    cyc();
    chk("drain_valid", out_valid, 0);
    chk("drain_sel",   sel, 1);
    chk("drain_data",  out_data, 8'hA1);

    // Burst lock behaviour.
    do_reset();
`ifdef MUX_ARB_LOCK_EN
    lock_gnt[0] = 4'b0001; lock_gnt[1] = 4'b0001;
    lock_gnt[2] = 4'b0001; lock_gnt[3] = 4'b0010;
`else
    lock_gnt[0] = 4'b0001; lock_gnt[1] = 4'b0010;
    lock_gnt[2] = 4'b0001; lock_gnt[3] = 4'b0010;
`endif
    cnt0 = 0;
    cnt1 = 0;
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      set_word(0, W'(8'h10 + cnt0));
      set_word(1, W'(8'h20 + cnt1));
      last = {3'b001, (cnt0 == 2)};
      #1;
      chk("lock_gnt", gnt, lock_gnt[k]);
      if (gnt[0]) cnt0++;
      if (gnt[1]) cnt1++;
      cyc();
    end
    req  = 4'b0000;
    last = 4'b0000;

    // Asynchronous reset while holding requester 3's word.
    do_reset();
    set_word(3, 8'h5C);
    req = 4'b1000;
    cyc();
    req = 4'b0000;
    #1;
    chk("pre_rst_sel",   sel, 3);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data",  out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_word(0, 8'h77);
    req = 4'b1001;
    #1;
    chk("post_rst_gnt", gnt, 4'b0001);
    cyc();
    req = 4'b0000;
    chk("post_rst_sel",  sel, 0);
    chk("post_rst_data", out_data, 8'h77);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
